// File: rtl/lcd_cmd_sequencer.sv
// Host-side command sequencer for LCD_CTRL: queues 3-bit commands in a small FIFO, issues them
// under busy flow control, and streams the image ROM onto datain behind every LOAD command.
module lcd_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned N_PIX      = 108,
    parameter int unsigned ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        host_cmd,
    input  logic              host_valid,
    output logic              host_ready,
    output logic              img_rd,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [7:0]        img_data,
    input  logic              busy,
    output logic [2:0]        cmd,
    output logic              cmd_valid,
    output logic [7:0]        datain,
    output logic [7:0]        issued_cnt,
    output logic              seq_idle
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_PIX - 1);
    localparam logic [CntW-1:0]   FullCnt  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StGap
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [2:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full_q, full_d;
    logic            push, pop;
    logic            fifo_empty;
    logic [2:0]      head;

    assign host_ready = ~full_q;
    assign push       = host_valid & ~full_q;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == FullCnt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= host_cmd;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM and image stream
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [2:0]        cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              img_rd_q, img_rd_d;
    logic [ADDR_W-1:0] img_addr_q, img_addr_d;
    logic              pix_vld_q, pix_vld_d;
    logic [7:0]        issued_q, issued_d;
    logic              issue;

    assign issue = (state_q == StIdle) && !fifo_empty && !busy;
    assign pop   = issue;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        img_rd_d    = 1'b0;
        img_addr_d  = img_addr_q;
        issued_d    = issued_q;
        // ROM data lags the read strobe by one cycle, so pixel-valid tracks img_rd delayed.
        pix_vld_d   = img_rd_q;

        unique case (state_q)
            StIdle: begin
                if (issue) begin
                    cmd_valid_d = 1'b1;
                    cmd_d       = head;
                    issued_d    = issued_q + 8'd1;
                    if (head == 3'd0) begin
                        img_rd_d   = 1'b1;
                        img_addr_d = '0;
                        state_d    = StLoad;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
            StLoad: begin
                if (img_rd_q) begin
                    img_addr_d = img_addr_q + 1'b1;
                    img_rd_d   = (img_addr_q != LastAddr);
                end
                // Last pixel is on datain when data is valid but no further read is pending.
                if (pix_vld_q && !img_rd_q) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cmd_q       <= 3'd0;
            cmd_valid_q <= 1'b0;
            img_rd_q    <= 1'b0;
            img_addr_q  <= '0;
            pix_vld_q   <= 1'b0;
            issued_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            img_rd_q    <= img_rd_d;
            img_addr_q  <= img_addr_d;
            pix_vld_q   <= pix_vld_d;
            issued_q    <= issued_d;
        end
    end

    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign img_rd     = img_rd_q;
    assign img_addr   = img_addr_q;
    assign issued_cnt = issued_q;
    assign datain     = pix_vld_q ? img_data : 8'd0;
    assign seq_idle   = (state_q == StIdle) && fifo_empty;

endmodule
